// File: rtl/mem_byte_sequencer_pkg.sv
// Shared state encoding, access lengths and port identifiers for the byte-serial
// memory sequencer.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DREAD,
        S_DWRITE,
        S_ERR,
        S_RESP
    } seq_state_t;

    localparam int IFETCH_LEN = 10;
    localparam int DATA_LEN   = 8;

    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    // Unsigned 64-bit compare against the last legal start address, so an address
    // close to 2^64 can never wrap into range.
    function automatic logic out_of_range(input logic [63:0] addr,
                                          input int          mem_bytes,
                                          input int          len);
        return addr > 64'(mem_bytes - len);
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// Requester-side handshake bundle: instruction-fetch port and data port.
interface mem_byte_sequencer_if;

    logic        i_req;
    logic [63:0] i_addr;
    logic        i_ack;
    logic [79:0] i_instr;
    logic        i_ok;

    logic        d_req;
    logic        d_wr;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        d_ok;

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  i_ack, i_instr, i_ok, d_ack, d_rdata, d_ok
    );

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output i_ack, i_instr, i_ok, d_ack, d_rdata, d_ok
    );

endinterface

// File: rtl/mem_byte_sequencer_arb.sv
// Two-way fetch/data arbiter: a lone request wins, a tie goes to the port that
// did not win last time.
module mem_grant_arb
    import mem_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       i_req,
    input  logic       d_req,
    output logic [1:0] grant,
    output logic       grant_valid
);

    logic last_grant_reg;

    always_comb begin
        grant = '0;
        if (enable) begin
            if (i_req && d_req) begin
                if (last_grant_reg == FETCH) begin
                    grant[DATA] = 1'b1;
                end else begin
                    grant[FETCH] = 1'b1;
                end
            end else if (i_req) begin
                grant[FETCH] = 1'b1;
            end else if (d_req) begin
                grant[DATA] = 1'b1;
            end
        end
    end

    assign grant_valid = |grant;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_reg <= FETCH;
        end else if (grant_valid) begin
            last_grant_reg <= grant[DATA] ? DATA : FETCH;
        end
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Serialises 10-byte fetches and 8-byte data reads/writes onto one byte-wide RAM,
// one byte per cycle, with range checking and a one-cycle ack per response.
module mem_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int MEM_AW    = 10
) (
    input  logic                clk,
    input  logic                reset,
    mem_byte_sequencer_if.slave bus,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic                mem_we,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    output logic                busy
);

    seq_state_t        state_reg;
    logic              port_reg;
    logic [3:0]        cnt_reg;
    logic [MEM_AW-1:0] base_reg;
    logic [63:0]       wdata_reg;

    logic              i_ack_reg;
    logic [79:0]       i_instr_reg;
    logic              i_ok_reg;
    logic              d_ack_reg;
    logic [63:0]       d_rdata_reg;
    logic              d_ok_reg;
    logic [MEM_AW-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [7:0]        mem_wdata_reg;
    logic              busy_reg;
    logic              i_ack_d_reg;
    logic              d_ack_d_reg;

    logic [1:0]        grant;
    logic              grant_valid;
    logic              i_req_m;
    logic              d_req_m;
    logic              i_range_err;
    logic              d_range_err;
    logic              capturing;
    logic [3:0]        cnt_next;
    logic [3:0]        last_idx;
    logic [5:0]        wsel;

    logic [IFETCH_LEN-1:0][7:0] byte_now;
    logic [79:0]                fetch_word;
    logic [63:0]                data_word;

    // A port whose ack was in the previous cycle must not be re-granted, even if
    // its requester is still (illegally) holding req.
    assign i_req_m = bus.i_req && !i_ack_d_reg;
    assign d_req_m = bus.d_req && !d_ack_d_reg;

    mem_grant_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .enable      (state_reg == S_IDLE),
        .i_req       (i_req_m),
        .d_req       (d_req_m),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign i_range_err = out_of_range(bus.i_addr, MEM_BYTES, IFETCH_LEN);
    assign d_range_err = out_of_range(bus.d_addr, MEM_BYTES, DATA_LEN);

    assign capturing = (state_reg == S_FETCH) || (state_reg == S_DREAD);
    assign cnt_next  = cnt_reg + 4'd1;
    assign last_idx  = (state_reg == S_FETCH) ? 4'(IFETCH_LEN - 1) : 4'(DATA_LEN - 1);
    assign wsel      = {cnt_next[2:0], 3'b000};

    // One capture register per byte slot; the byte arriving in the current cycle
    // bypasses its slot so the final word is complete at the last capture edge.
    generate
        for (genvar gi = 0; gi < IFETCH_LEN; gi++) begin : g_slot
            logic [7:0] slot_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    slot_reg <= '0;
                end else if (capturing && cnt_reg == 4'(gi)) begin
                    slot_reg <= mem_rdata;
                end
            end

            assign byte_now[gi] = (cnt_reg == 4'(gi)) ? mem_rdata : slot_reg;
            assign fetch_word[79-8*gi -: 8] = byte_now[gi];
        end

        for (genvar gi = 0; gi < DATA_LEN; gi++) begin : g_dword
            assign data_word[8*gi +: 8] = byte_now[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            port_reg      <= FETCH;
            cnt_reg       <= '0;
            base_reg      <= '0;
            wdata_reg     <= '0;
            i_ack_reg     <= 1'b0;
            i_instr_reg   <= '0;
            i_ok_reg      <= 1'b0;
            d_ack_reg     <= 1'b0;
            d_rdata_reg   <= '0;
            d_ok_reg      <= 1'b0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            i_ack_d_reg   <= 1'b0;
            d_ack_d_reg   <= 1'b0;
        end else begin
            i_ack_d_reg <= i_ack_reg;
            d_ack_d_reg <= d_ack_reg;
            i_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        busy_reg <= 1'b1;
                        cnt_reg  <= '0;
                        if (grant[FETCH]) begin
                            port_reg <= FETCH;
                            if (i_range_err) begin
                                state_reg <= S_ERR;
                            end else begin
                                state_reg    <= S_FETCH;
                                base_reg     <= bus.i_addr[MEM_AW-1:0];
                                mem_addr_reg <= bus.i_addr[MEM_AW-1:0];
                            end
                        end else begin
                            port_reg  <= DATA;
                            wdata_reg <= bus.d_wdata;
                            if (d_range_err) begin
                                state_reg <= S_ERR;
                            end else begin
                                base_reg     <= bus.d_addr[MEM_AW-1:0];
                                mem_addr_reg <= bus.d_addr[MEM_AW-1:0];
                                if (bus.d_wr) begin
                                    state_reg     <= S_DWRITE;
                                    mem_we_reg    <= 1'b1;
                                    mem_wdata_reg <= bus.d_wdata[7:0];
                                end else begin
                                    state_reg <= S_DREAD;
                                end
                            end
                        end
                    end
                end

                S_FETCH, S_DREAD, S_DWRITE: begin
                    if (cnt_reg == last_idx) begin
                        state_reg  <= S_RESP;
                        mem_we_reg <= 1'b0;
                        if (state_reg == S_FETCH) begin
                            i_ack_reg   <= 1'b1;
                            i_ok_reg    <= 1'b1;
                            i_instr_reg <= fetch_word;
                        end else begin
                            d_ack_reg <= 1'b1;
                            d_ok_reg  <= 1'b1;
                            if (state_reg == S_DREAD) begin
                                d_rdata_reg <= data_word;
                            end
                        end
                    end else begin
                        cnt_reg      <= cnt_next;
                        mem_addr_reg <= base_reg + MEM_AW'(cnt_next);
                        if (state_reg == S_DWRITE) begin
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= wdata_reg[wsel +: 8];
                        end
                    end
                end

                S_ERR: begin
                    state_reg <= S_RESP;
                    if (port_reg == FETCH) begin
                        i_ack_reg   <= 1'b1;
                        i_ok_reg    <= 1'b0;
                        i_instr_reg <= '0;
                    end else begin
                        d_ack_reg   <= 1'b1;
                        d_ok_reg    <= 1'b0;
                        d_rdata_reg <= '0;
                    end
                end

                S_RESP: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg  <= S_IDLE;
                    busy_reg   <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_ack   = i_ack_reg;
    assign bus.i_instr = i_instr_reg;
    assign bus.i_ok    = i_ok_reg;
    assign bus.d_ack   = d_ack_reg;
    assign bus.d_rdata = d_rdata_reg;
    assign bus.d_ok    = d_ok_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_we      = mem_we_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Self-checking bench for mem_byte_sequencer: vector table, randomized traffic
// against an array-based reference model, and hand-written corner sequences.
module tb_mem_byte_sequencer;

    logic       clk;
    logic       reset;
    logic [9:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       tb_init;

    mem_byte_sequencer_if bus ();

    mem_byte_sequencer #(
        .MEM_BYTES (1024),
        .MEM_AW    (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: asynchronous read, write committed at the clock edge.
    logic [7:0] ram [0:1023];
    logic [7:0] ref_mem [0:1023];

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            16'h10:  return 8'h30;
            16'h11:  return 8'hF2;
            16'h12:  return 8'h01;
            16'h13:  return 8'h02;
            16'h14:  return 8'h03;
            16'h15:  return 8'h04;
            16'h16:  return 8'h05;
            16'h17:  return 8'h06;
            16'h18:  return 8'h07;
            16'h19:  return 8'h08;
            default: return 8'((a * 37) + 5);
        endcase
    endfunction

    always @(posedge clk) begin
        if (tb_init) begin
            for (int a = 0; a < 1024; a++) ram[a] <= init_byte(a);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = ram[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int txn_no   = 0;

    logic [79:0] model_i_instr = '0;
    logic [63:0] model_d_rdata = '0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] model_fetch(input logic [9:0] a);
        logic [79:0] w = '0;
        for (int k = 0; k < 10; k++) w = (w << 8) | 80'(ref_mem[int'(a) + k]);
        return w;
    endfunction

    function automatic logic [63:0] model_read(input logic [9:0] a);
        logic [63:0] w = '0;
        for (int k = 7; k >= 0; k--) w = (w << 8) | 64'(ref_mem[int'(a) + k]);
        return w;
    endfunction

    task automatic do_txn(input string name, input bit fetch, input bit wr,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output bit ok_o, output logic [79:0] data_o);
        int          len;
        int          busy_at;
        int          ack_at;
        int          we_cnt;
        int          exp_lat;
        int          act_lat;
        bit          exp_ok;
        logic [79:0] exp_data;

        len    = fetch ? 10 : 8;
        exp_ok = (addr <= 64'(1024 - len));
        if (!exp_ok)    exp_data = '0;
        else if (fetch) exp_data = model_fetch(addr[9:0]);
        else if (wr)    exp_data = {16'h0, model_d_rdata};
        else            exp_data = {16'h0, model_read(addr[9:0])};
        exp_lat = !exp_ok ? 2 : (fetch ? 11 : 9);

        @(negedge clk);
        if (fetch) begin
            bus.i_req  = 1'b1;
            bus.i_addr = addr;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_wr    = wr;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end
        busy_at = -1;
        ack_at  = -1;
        we_cnt  = 0;
        ok_o    = 1'b0;
        data_o  = '0;
        for (int c = 1; c <= 40 && ack_at < 0; c++) begin
            @(negedge clk);
            if (busy && busy_at < 0) busy_at = c;
            if (mem_we) we_cnt++;
            if (fetch ? bus.i_ack : bus.d_ack) begin
                ack_at = c;
                ok_o   = fetch ? bus.i_ok : bus.d_ok;
                data_o = fetch ? bus.i_instr : {16'h0, bus.d_rdata};
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        act_lat = (busy_at < 0 || ack_at < 0) ? -1 : ack_at - (busy_at - 1);

        check($sformatf("%s ack_seen", name), 80'(ack_at > 0), 80'(1));
        check($sformatf("%s latency", name), 80'(act_lat), 80'(exp_lat));
        check($sformatf("%s ok", name), 80'(ok_o), 80'(exp_ok));
        check($sformatf("%s data", name), data_o, exp_data);
        check($sformatf("%s we_cycles", name), 80'(we_cnt), 80'((!fetch && wr && exp_ok) ? 8 : 0));
        $display("txn %0d %s %s addr=%h ok=%0b data=%h lat=%0d we=%0d", txn_no, name,
                 fetch ? "fetch" : (wr ? "write" : "read"), addr, ok_o, data_o, act_lat, we_cnt);
        txn_no++;

        if (fetch) begin
            model_i_instr = exp_data;
        end else if (!exp_ok) begin
            model_d_rdata = '0;
        end else if (wr) begin
            for (int k = 0; k < 8; k++) ref_mem[int'(addr[9:0]) + k] = wdata[8*k +: 8];
        end else begin
            model_d_rdata = exp_data[63:0];
        end
        @(negedge clk);
    endtask

    // Both ports request together: data must win (last grant was fetch), and the
    // fetch must be granted in the IDLE cycle right after the data ack.
    task automatic pair_test(input string name);
        int          i_c = -1;
        int          d_c = -1;
        logic [79:0] i_got = '0;
        logic [63:0] d_got = '0;
        logic [79:0] exp_i;
        logic [63:0] exp_d;
        exp_i = model_fetch(10'h10);
        exp_d = model_read(10'h20);
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 64'h10;
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = 64'h20;
        for (int c = 1; c <= 60 && (i_c < 0 || d_c < 0); c++) begin
            @(negedge clk);
            if (bus.d_ack && d_c < 0) begin
                d_c = c;
                d_got = bus.d_rdata;
                bus.d_req = 1'b0;
            end
            if (bus.i_ack && i_c < 0) begin
                i_c = c;
                i_got = bus.i_instr;
                bus.i_req = 1'b0;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check($sformatf("%s both_acked", name), 80'(i_c > 0 && d_c > 0), 80'(1));
        check($sformatf("%s data_first", name), 80'(d_c > 0 && d_c < i_c), 80'(1));
        check($sformatf("%s data_latency", name), 80'(d_c), 80'(9));
        check($sformatf("%s fetch_follows", name), 80'(i_c - d_c), 80'(12));
        check($sformatf("%s d_rdata", name), {16'h0, d_got}, {16'h0, exp_d});
        check($sformatf("%s i_instr", name), i_got, exp_i);
        $display("txn %0d %s pair d_ack@%0d i_ack@%0d", txn_no, name, d_c, i_c);
        txn_no++;
        model_i_instr = exp_i;
        model_d_rdata = exp_d;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        bit          fetch;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          exp_ok;
        bit          chk;
        logic [79:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [79:0] data;
        int          mism;
        int          busy_c;
        bit          saw_ack;

        vecs[0]  = '{"fetch_0x10",   1'b1, 1'b0, 64'h10,  64'h0, 1'b1, 1'b1, 80'h30F20102030405060708};
        vecs[1]  = '{"write_0x100",  1'b0, 1'b1, 64'h100, 64'h8877665544332211, 1'b1, 1'b0, 80'h0};
        vecs[2]  = '{"read_0x100",   1'b0, 1'b0, 64'h100, 64'h0, 1'b1, 1'b1, 80'h8877665544332211};
        vecs[3]  = '{"read_1017",    1'b0, 1'b0, 64'd1017, 64'h0, 1'b0, 1'b1, 80'h0};
        vecs[4]  = '{"fetch_1014",   1'b1, 1'b0, 64'd1014, 64'h0, 1'b1, 1'b0, 80'h0};
        vecs[5]  = '{"fetch_1015",   1'b1, 1'b0, 64'd1015, 64'h0, 1'b0, 1'b1, 80'h0};
        vecs[6]  = '{"read_top",     1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 1'b1, 80'h0};
        vecs[7]  = '{"write_1016",   1'b0, 1'b1, 64'd1016, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 80'h0};
        vecs[8]  = '{"write_1017",   1'b0, 1'b1, 64'd1017, 64'h1234567812345678, 1'b0, 1'b0, 80'h0};
        vecs[9]  = '{"fetch_top",    1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0, 1'b1, 80'h0};
        vecs[10] = '{"read_1016",    1'b0, 1'b0, 64'd1016, 64'h0, 1'b1, 1'b1, 80'hDEADBEEF_CAFEF00D};

        for (int a = 0; a < 1024; a++) ref_mem[a] = init_byte(a);

        reset       = 1'b0;
        tb_init     = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        repeat (3) @(negedge clk);
        check("reset i_ack", 80'(bus.i_ack), 80'(0));
        check("reset d_ack", 80'(bus.d_ack), 80'(0));
        check("reset i_instr", bus.i_instr, 80'(0));
        check("reset d_rdata", 80'(bus.d_rdata), 80'(0));
        check("reset oks", {78'h0, bus.i_ok, bus.d_ok}, 80'(0));
        check("reset mem_bus", {61'h0, mem_addr, mem_we, mem_wdata}, 80'(0));
        check("reset busy", 80'(busy), 80'(0));
        tb_init = 1'b0;
        reset   = 1'b1;

        pair_test("arb_from_reset");
        pair_test("arb_repeat");

        for (int v = 0; v < 11; v++) begin
            do_txn(vecs[v].name, vecs[v].fetch, vecs[v].wr, vecs[v].addr, vecs[v].wdata, ok, data);
            check($sformatf("%s table_ok", vecs[v].name), 80'(ok), 80'(vecs[v].exp_ok));
            if (vecs[v].chk) check($sformatf("%s table_data", vecs[v].name), data, vecs[v].exp_data);
        end

        for (int r = 0; r < 40; r++) begin
            logic [63:0] addr;
            int          mode;
            bit          fetch;
            bit          wr;
            mode  = int'($urandom_range(0, 9));
            fetch = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            if (mode < 7)       addr = 64'($urandom_range(0, 1023));
            else if (mode == 7) addr = 64'($urandom_range(1010, 1023));
            else if (mode == 8) addr = {$urandom, $urandom};
            else                addr = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
            do_txn($sformatf("rand%0d", r), fetch, wr, addr, {$urandom, $urandom}, ok, data);
        end

        mism = 0;
        for (int a = 0; a < 1024; a++) if (ram[a] !== ref_mem[a]) mism++;
        check("ram_vs_model", 80'(mism), 80'(0));

        // Reset asserted during the third byte cycle of a write.
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b1;
        bus.d_addr  = 64'h200;
        bus.d_wdata = 64'hAABBCCDD_EEFF0102;
        busy_c  = 0;
        saw_ack = 1'b0;
        for (int c = 0; c < 20 && busy_c < 3; c++) begin
            @(negedge clk);
            if (busy) busy_c++;
            if (bus.d_ack) saw_ack = 1'b1;
        end
        check("abort reached_byte3", 80'(busy_c), 80'(3));
        reset     = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        if (bus.d_ack) saw_ack = 1'b1;
        check("abort no_ack", 80'(saw_ack), 80'(0));
        check("abort busy", 80'(busy), 80'(0));
        check("abort mem_we", 80'(mem_we), 80'(0));
        check("abort mem_bus", {62'h0, mem_addr, mem_wdata}, 80'(0));
        check("abort outputs", {bus.i_instr}, 80'(0));
        check("abort d_rdata", {14'h0, bus.d_ok, bus.i_ok, bus.d_rdata}, 80'(0));
        reset = 1'b1;
        check("abort written", {56'h0, ram[16'h200], ram[16'h201], ram[16'h202]}, {56'h0, 24'h0201FF});
        check("abort untouched",
              {40'h0, ram[16'h203], ram[16'h204], ram[16'h205], ram[16'h206], ram[16'h207]},
              {40'h0, ref_mem[16'h203], ref_mem[16'h204], ref_mem[16'h205], ref_mem[16'h206], ref_mem[16'h207]});
        $display("txn %0d abort write 0x200 after %0d byte cycles", txn_no, busy_c);
        txn_no++;
        ref_mem[16'h200] = 8'h02;
        ref_mem[16'h201] = 8'h01;
        ref_mem[16'h202] = 8'hFF;
        model_d_rdata = '0;
        model_i_instr = '0;

        // Requester holds d_req through its ack and the following cycle.
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = 64'h100;
        saw_ack = 1'b0;
        for (int c = 0; c < 30 && !saw_ack; c++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                saw_ack = 1'b1;
                check("hold read_data", 80'(bus.d_rdata), 80'(model_read(10'h100)));
            end
        end
        check("hold ack_seen", 80'(saw_ack), 80'(1));
        @(negedge clk);
        @(negedge clk);
        check("hold no_regrant", 80'(busy), 80'(0));
        bus.d_req = 1'b0;
        $display("txn %0d held-request read 0x100", txn_no);
        txn_no++;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
